riscv_timer_intr: RTL and testbench



---
 rtl/riscv_timer_pkg.sv | 31 +++
 rtl/timer_prescaler.sv | 28 ++
 rtl/riscv_timer_intr.sv | 147 ++++++++++++++
 tb/tb_riscv_timer_intr.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_timer_pkg.sv
// Shared constants for the machine-timer peripheral: register offsets,
// CTRL field positions and the mtimecmp reset value.
package riscv_timer_pkg;

  localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
  localparam logic [4:0] CTRL_OFF        = 5'h10;
  localparam logic [4:0] STATUS_OFF      = 5'h14;

  // Word indices as seen on addr[4:2]
  localparam logic [2:0] MTIME_LO_IDX    = MTIME_LO_OFF[4:2];
  localparam logic [2:0] MTIME_HI_IDX    = MTIME_HI_OFF[4:2];
  localparam logic [2:0] MTIMECMP_LO_IDX = MTIMECMP_LO_OFF[4:2];
  localparam logic [2:0] MTIMECMP_HI_IDX = MTIMECMP_HI_OFF[4:2];
  localparam logic [2:0] CTRL_IDX        = CTRL_OFF[4:2];
  localparam logic [2:0] STATUS_IDX      = STATUS_OFF[4:2];

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PS_LSB   = 8;
  localparam int STATUS_CMP_BIT  = 0;
  localparam int STATUS_INTR_BIT = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [2:0] word_idx_of(input logic [4:0] byte_addr);
    return byte_addr[4:2];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: while enabled, emits one tick every (prescale+1) cycles.
// A clear restarts the count from zero.
module timer_prescaler #(
  parameter int PSW = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en,
  input  logic [PSW-1:0] prescale,
  input  logic           clr,
  output logic           tick
);

  logic [PSW-1:0] ps_cnt_reg;

  assign tick = en && (ps_cnt_reg == prescale);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_cnt_reg <= '0;
    end else if (clr) begin
      ps_cnt_reg <= '0;
    end else if (en) begin
      ps_cnt_reg <= tick ? '0 : ps_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_timer_intr.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// level interrupt while enabled and mtime >= mtimecmp, single-cycle-ack bus.
module riscv_timer_intr
  import riscv_timer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ADDRW = 12,
  parameter int PSW   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o,
  output logic             ack_o,
  output logic             t_intr
);

  logic [2:0]     word_idx;
  logic           wr;
  logic           rd;
  logic           unused_addr;

  logic [63:0]    mtime_reg;
  logic [63:0]    mtime_next;
  logic [63:0]    mtimecmp;
  logic [31:0]    hi_shadow_reg;
  logic           en_reg;
  logic [PSW-1:0] prescale_reg;
  logic           ack_reg;
  logic [DW-1:0]  rdata_reg;
  logic [DW-1:0]  read_data;
  logic           intr_reg;
  logic           cmp_hit;
  logic           tick;
  logic           ctrl_wr;

  assign word_idx    = word_idx_of(addr_i[4:0]);
  assign unused_addr = ^{addr_i[ADDRW-1:5], addr_i[1:0]};
  assign wr          = req_i && we_i;
  assign rd          = req_i && !we_i;
  assign ctrl_wr     = wr && (word_idx == CTRL_IDX);
  assign cmp_hit     = (mtime_reg >= mtimecmp);

  timer_prescaler #(
    .PSW (PSW)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en       (en_reg),
    .prescale (prescale_reg),
    .clr      (ctrl_wr),
    .tick     (tick)
  );

  // A bus write to either half suppresses that cycle's increment entirely.
  always_comb begin
    mtime_next = mtime_reg;
    if (wr && (word_idx == MTIME_LO_IDX)) begin
      mtime_next[31:0] = wdata_i[31:0];
    end else if (wr && (word_idx == MTIME_HI_IDX)) begin
      mtime_next[63:32] = wdata_i[31:0];
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_reg <= '0;
    end else begin
      mtime_reg <= mtime_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_cmp_half
    logic [31:0] half_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        half_reg <= MTIMECMP_RST[gi*32 +: 32];
      end else if (wr && (word_idx == 3'(MTIMECMP_LO_IDX + gi))) begin
        half_reg <= wdata_i[31:0];
      end
    end

    assign mtimecmp[gi*32 +: 32] = half_reg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_reg       <= 1'b0;
      prescale_reg <= '0;
    end else if (ctrl_wr) begin
      en_reg       <= wdata_i[CTRL_EN_BIT];
      prescale_reg <= wdata_i[CTRL_PS_LSB +: PSW];
    end
  end

  // Reading the low half freezes the high half so a LO-then-HI pair is coherent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_shadow_reg <= '0;
    end else if (rd && (word_idx == MTIME_LO_IDX)) begin
      hi_shadow_reg <= mtime_reg[63:32];
    end
  end

  always_comb begin
    read_data = '0;
    case (word_idx)
      MTIME_LO_IDX:    read_data[31:0] = mtime_reg[31:0];
      MTIME_HI_IDX:    read_data[31:0] = hi_shadow_reg;
      MTIMECMP_LO_IDX: read_data[31:0] = mtimecmp[31:0];
      MTIMECMP_HI_IDX: read_data[31:0] = mtimecmp[63:32];
      CTRL_IDX: begin
        read_data[CTRL_EN_BIT]          = en_reg;
        read_data[CTRL_PS_LSB +: PSW]   = prescale_reg;
      end
      STATUS_IDX: begin
        read_data[STATUS_CMP_BIT]  = cmp_hit;
        read_data[STATUS_INTR_BIT] = intr_reg;
      end
      default: read_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
      intr_reg  <= 1'b0;
    end else begin
      ack_reg   <= req_i;
      rdata_reg <= rd ? read_data : '0;
      intr_reg  <= en_reg && cmp_hit;
    end
  end

  assign ack_o   = ack_reg;
  assign rdata_o = rdata_reg;
  assign t_intr  = intr_reg;

endmodule

// File: tb/tb_riscv_timer_intr.sv
// Directed bench for riscv_timer_intr: a cycle model checks every output each
// cycle, and directed transactions pin the model with hand-computed values.
module tb_riscv_timer_intr;

  localparam int DW    = 32;
  localparam int ADDRW = 12;
  localparam int PSW   = 8;

  logic             clk    = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req    = 1'b0;
  logic             we     = 1'b0;
  logic [ADDRW-1:0] addr   = '0;
  logic [DW-1:0]    wdata  = '0;
  logic [DW-1:0]    rdata;
  logic             ack;
  logic             t_intr;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_timer_intr #(
    .DW    (DW),
    .ADDRW (ADDRW),
    .PSW   (PSW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ack_o   (ack),
    .t_intr  (t_intr)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state and what the outputs must show next cycle
  logic [63:0] m_mtime  = '0;
  logic [63:0] m_cmp    = '1;
  logic [31:0] m_shadow = '0;
  logic        m_en     = 1'b0;
  int          m_ps     = 0;
  int          m_run    = 0;
  logic        e_ack    = 1'b0;
  logic [31:0] e_rdata  = '0;
  logic        e_intr   = 1'b0;

  function automatic logic [31:0] model_read(input logic [2:0] w);
    logic [31:0] v;
    v = '0;
    case (w)
      3'd0: v = m_mtime[31:0];
      3'd1: v = m_shadow;
      3'd2: v = m_cmp[31:0];
      3'd3: v = m_cmp[63:32];
      3'd4: v = {16'h0, 8'(m_ps), 7'h0, m_en};
      3'd5: v = {30'h0, e_intr, (m_mtime >= m_cmp)};
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_mtime  <= '0;
      m_cmp    <= '1;
      m_shadow <= '0;
      m_en     <= 1'b0;
      m_ps     <= 0;
      m_run    <= 0;
      e_ack    <= 1'b0;
      e_rdata  <= '0;
      e_intr   <= 1'b0;
    end else begin
      e_ack   <= req;
      e_rdata <= (req && !we) ? model_read(addr[4:2]) : 32'h0;
      e_intr  <= m_en && (m_mtime >= m_cmp);
      if (req && !we && addr[4:2] == 3'd0) m_shadow <= m_mtime[63:32];
      if (req && we && addr[4:2] == 3'd0)
        m_mtime <= {m_mtime[63:32], wdata};
      else if (req && we && addr[4:2] == 3'd1)
        m_mtime <= {wdata, m_mtime[31:0]};
      else if (m_en && (m_run % (m_ps + 1)) == m_ps)
        m_mtime <= m_mtime + 64'd1;
      if (req && we && addr[4:2] == 3'd2) m_cmp <= {m_cmp[63:32], wdata};
      if (req && we && addr[4:2] == 3'd3) m_cmp <= {wdata, m_cmp[31:0]};
      if (req && we && addr[4:2] == 3'd4) begin
        m_en  <= wdata[0];
        m_ps  <= int'(wdata[15:8]);
        m_run <= 0;
      end else if (m_en) begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the ack edge.
  task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 1'b0;
    check("ack_pulse", ack, 1);
    r = rdata;
    $display("bus %s addr=%03h wdata=%08h rdata=%08h t_intr=%0b",
             w ? "WR" : "RD", a, d, rdata, t_intr);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] rst_exp [6];
    int rise;

    rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

    fork
      forever begin
        @(negedge clk);
        check("mon_ack", ack, e_ack);
        check("mon_rdata", rdata, e_rdata);
        check("mon_t_intr", t_intr, e_intr);
      end
    join_none

    step(3);
    rst_ni = 1'b1;
    step(1);

    // Reset values
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, 12'(i * 4), 32'h0, r);
      check("reset_read", r, rst_exp[i]);
    end
    check("reset_t_intr", t_intr, 0);

    // Interrupt at prescale 0
    bus(1'b1, 12'h00C, 32'h0, r);
    bus(1'b1, 12'h008, 32'd10, r);
    bus(1'b1, 12'h010, 32'h1, r);
    rise = -1;
    for (int k = 0; k < 50; k++) begin
      if (t_intr) begin
        rise = k;
        break;
      end
      step(1);
    end
    check("intr_rise_delay", 64'(rise), 64'd11);
    bus(1'b0, 12'h014, 32'h0, r);
    check("status_both", r, 32'h3);
    bus(1'b1, 12'h00C, 32'hFFFF_FFFF, r);
    check("intr_hold_at_ack", t_intr, 1);
    step(1);
    check("intr_fall", t_intr, 0);
    bus(1'b1, 12'h008, 32'hFFFF_FFFF, r);

    // Prescale 3: ticks on the 4th, 8th, ... enabled cycle
    bus(1'b1, 12'h010, 32'h0, r);
    bus(1'b1, 12'h000, 32'h0, r);
    bus(1'b1, 12'h004, 32'h0, r);
    bus(1'b1, 12'h010, 32'h301, r);
    step(40);
    bus(1'b0, 12'h000, 32'h0, r);
    n_checks++;
    if (r < 32'd9 || r > 32'd11) begin
      n_fail++;
      $display("FAIL ps3_mtime: got %0d expected 10 (+/-1)", r);
    end
    bus(1'b0, 12'h010, 32'h0, r);
    check("ctrl_readback", r, 32'h301);

    // Wrap and shadow read
    bus(1'b1, 12'h010, 32'h0, r);
    bus(1'b1, 12'h004, 32'hFFFF_FFFF, r);
    bus(1'b1, 12'h000, 32'hFFFF_FFFE, r);
    bus(1'b1, 12'h00C, 32'h0, r);
    bus(1'b1, 12'h008, 32'd5, r);
    bus(1'b1, 12'h010, 32'h1, r);
    bus(1'b0, 12'h000, 32'h0, r);
    check("wrap_lo", r, 32'hFFFF_FFFE);
    step(1);
    bus(1'b0, 12'h004, 32'h0, r);
    check("shadow_hi", r, 32'hFFFF_FFFF);
    check("intr_after_wrap", t_intr, 0);
    bus(1'b0, 12'h000, 32'h0, r);
    check("post_wrap_lo", r, 32'h1);
    rise = -1;
    for (int k = 0; k < 50; k++) begin
      if (t_intr) begin
        rise = k;
        break;
      end
      step(1);
    end
    check("wrap_intr_rise", 64'(rise), 64'd4);

    // Write vs tick collision at prescale 1
    bus(1'b1, 12'h00C, 32'hFFFF_FFFF, r);
    bus(1'b1, 12'h008, 32'hFFFF_FFFF, r);
    bus(1'b1, 12'h010, 32'h101, r);
    step(1);
    bus(1'b1, 12'h000, 32'd100, r);
    step(3);
    bus(1'b0, 12'h000, 32'h0, r);
    check("collision_lo", r, 32'd101);

    // Unmapped offsets
    bus(1'b0, 12'h01C, 32'h0, r);
    check("unmapped_1c", r, 32'h0);
    bus(1'b1, 12'h01C, 32'd123, r);
    bus(1'b0, 12'h018, 32'h0, r);
    check("unmapped_18", r, 32'h0);
    bus(1'b0, 12'h010, 32'h0, r);
    check("ctrl_untouched", r, 32'h101);

    // Reset during a request
    req   = 1'b1;
    we    = 1'b1;
    addr  = 12'h010;
    wdata = 32'h0;
    #2;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    check("abort_no_ack", ack, 0);
    req = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    check("abort_no_ack_late", ack, 0);
    #2;
    rst_ni = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, 12'(i * 4), 32'h0, r);
      check("post_abort_read", r, rst_exp[i]);
    end
    check("post_abort_t_intr", t_intr, 0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
